sync_fifo_fwft: RTL

//  Single-clock FIFO for same-domain buffering, successor to the dual-clock FIFO.

---
 rtl/sync_fifo_fwft.sv | 59 +++++
 1 files changed

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with thresholds, sticky error flags and selectable FWFT read
module sync_fifo_fwft #(
    parameter int DSIZE  = 8,
    parameter int ASIZE  = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2,
    parameter bit FWFT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] AF = (ASIZE+1)'(AF_LVL);
    localparam logic [ASIZE:0] AE = (ASIZE+1)'(AE_LVL);
    logic [DSIZE-1:0] mem [0:DEPTH-1];
    logic [ASIZE:0]   wptr, rptr;
    logic [DSIZE-1:0] rdata_q;
    logic             we, re;
    assign rempty        = wptr == rptr;
    assign wfull         = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) && (wptr[ASIZE] != rptr[ASIZE]);
    assign count         = wptr - rptr;
    assign walmost_full  = count >= AF;
    assign ralmost_empty = count <= AE;
    assign we            = winc && !wfull;
    assign re            = rinc && !rempty;
    // FWFT exposes the head word directly; standard mode presents the registered pop
    assign rdata         = FWFT ? (rempty ? '0 : mem[rptr[ASIZE-1:0]]) : rdata_q;
    always_ff @(posedge clk) begin
        if (we) mem[wptr[ASIZE-1:0]] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            rdata_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we) wptr <= wptr + 1'b1;
            if (re) begin
                rptr    <= rptr + 1'b1;
                rdata_q <= mem[rptr[ASIZE-1:0]];
            end
            if (winc && wfull) overflow <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end
endmodule
